// File: rtl/fft_sample_loader.sv
// fft_sample_loader: streams one frame of complex samples into the FFT
// working memory at bit-reversed addresses, kicks the FFT with a stretched
// start pulse, then waits for the FFT's done level to cycle low->high before
// reporting frame completion and re-arming.
module fft_sample_loader #(
    parameter int N_POINTS  = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 64,
    parameter int START_LEN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              start_fft,
    input  logic              fft_done,
    output logic              frame_done,
    output logic              load_err,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);
    localparam int                SCNT_W   = (START_LEN < 2) ? 1 : $clog2(START_LEN + 1);
    localparam logic [SCNT_W-1:0] START_LEN_C = SCNT_W'(START_LEN);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_LOW  = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   count_q;
    logic [SCNT_W-1:0]   scnt_q;
    logic                in_ready_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_address_q;
    logic [DATA_W-1:0]   mem_data_q;
    logic                start_fft_q;
    logic                frame_done_q;
    logic                load_err_q;
    logic                busy_q;

    logic                hs_d;
    logic [ADDR_W-1:0]   addr_rev_d;
    logic [ADDR_W-1:0]   count_inc_d;

    // A transfer happens only when the registered ready meets valid.
    assign hs_d        = in_valid & in_ready_q;
    assign count_inc_d = count_q + 1'b1;

    // Bit-reversed write address: pure rewiring of the sample index.
    for (genvar g = 0; g < ADDR_W; g++) begin : g_bitrev
        assign addr_rev_d[g] = count_q[ADDR_W-1-g];
    end

    // Load/start/wait sequencer; every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            scnt_q        <= '0;
            in_ready_q    <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            start_fft_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            load_err_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            mem_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            load_err_q   <= 1'b0;
            case (state_q)
                // IDLE and LOAD share the handshake path; in IDLE count_q is
                // always zero, so the first sample lands at index 0. Ready is
                // raised in IDLE one cycle after re-entry from WAIT_HIGH.
                IDLE, LOAD: begin
                    if (state_q == IDLE) begin
                        in_ready_q <= 1'b1;
                    end
                    if (hs_d) begin
                        mem_we_q      <= 1'b1;
                        mem_address_q <= addr_rev_d;
                        mem_data_q    <= in_data;
                        if (count_q == LAST_IDX) begin
                            load_err_q <= ~in_last;
                            count_q    <= '0;
                            scnt_q     <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= START;
                        end else if (in_last) begin
                            load_err_q <= 1'b1;
                            count_q    <= '0;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            count_q    <= count_inc_d;
                            busy_q     <= 1'b1;
                            state_q    <= LOAD;
                        end
                    end
                end
                START: begin
                    if (scnt_q == START_LEN_C) begin
                        start_fft_q <= 1'b0;
                        state_q     <= WAIT_LOW;
                    end else begin
                        start_fft_q <= 1'b1;
                        scnt_q      <= scnt_q + 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (!fft_done) begin
                        state_q <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (fft_done) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    count_q     <= '0;
                    in_ready_q  <= 1'b0;
                    start_fft_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign mem_we      = mem_we_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign start_fft   = start_fft_q;
    assign frame_done  = frame_done_q;
    assign load_err    = load_err_q;
    assign busy        = busy_q;

endmodule
